// File: rtl/bcd_lap_stopwatch.sv
// rtl/bcd_lap_stopwatch.sv - multi-digit BCD stopwatch with lap freeze, prescaler and rotating LED bar
// Holds the running count, a lap snapshot and a one-hot LED bar advanced on each applied increment.
module bcd_lap_stopwatch #(
  parameter int DIGITS    = 4,
  parameter int TICK_DIV  = 100,
  parameter bit WRAP      = 1'b1,
  parameter int LED_WIDTH = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_stop_i,
  input  logic                  lap_i,
  input  logic                  clear_i,
  output logic [4*DIGITS-1:0]   digits_o,
  output logic                  running_o,
  output logic                  lap_active_o,
  output logic                  overflow_o,
  output logic                  tick_o,
  output logic [LED_WIDTH-1:0]  led_o
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [LED_WIDTH-1:0] LED_INIT = LED_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LAP   = 2'd2,
    ST_PAUSE = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [4*DIGITS-1:0]    count_q, count_d;
  logic [4*DIGITS-1:0]    lap_q, lap_d;
  logic [PW-1:0]          presc_q, presc_d;
  logic                   overflow_q, overflow_d;
  logic [LED_WIDTH-1:0]   led_q, led_d;

  logic [4*DIGITS-1:0]    count_inc;
  logic                   all_nines;
  logic                   counting;
  logic                   tick;
  logic [LED_WIDTH-1:0]   led_rot;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      lap_q      <= '0;
      presc_q    <= '0;
      overflow_q <= 1'b0;
      led_q      <= LED_INIT;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      lap_q      <= lap_d;
      presc_q    <= presc_d;
      overflow_q <= overflow_d;
      led_q      <= led_d;
    end
  end

  // Ripple increment; the carry left over past the top digit means the count was all 9s.
  always_comb begin
    logic carry;
    carry     = 1'b1;
    count_inc = count_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
    all_nines = carry;
  end

  assign counting = (state_q == ST_RUN) || (state_q == ST_LAP);
  assign tick     = counting && (presc_q == PRESC_LAST);
  assign led_rot  = {led_q[LED_WIDTH-2:0], led_q[LED_WIDTH-1]};

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    lap_d      = lap_q;
    presc_d    = presc_q;
    overflow_d = overflow_q;
    led_d      = led_q;

    if (clear_i) begin
      state_d    = ST_IDLE;
      count_d    = '0;
      lap_d      = '0;
      presc_d    = '0;
      overflow_d = 1'b0;
      led_d      = LED_INIT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_stop_i) begin
            state_d = ST_RUN;
            presc_d = '0;
          end
        end
        ST_RUN, ST_LAP: begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (start_stop_i) begin
            state_d = ST_PAUSE;
          end else if (lap_i) begin
            if (state_q == ST_RUN) begin
              state_d = ST_LAP;
              lap_d   = count_q;
            end else begin
              state_d = ST_RUN;
            end
          end
          // Saturation overrides any lap transition taken on the same edge.
          if (tick) begin
            if (all_nines) begin
              overflow_d = 1'b1;
              if (WRAP) begin
                count_d = '0;
                led_d   = led_rot;
              end else begin
                state_d = ST_PAUSE;
              end
            end else begin
              count_d = count_inc;
              led_d   = led_rot;
            end
          end
        end
        ST_PAUSE: begin
          if (start_stop_i) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign digits_o     = (state_q == ST_LAP) ? lap_q : count_q;
  assign running_o    = counting;
  assign lap_active_o = (state_q == ST_LAP);
  assign overflow_o   = overflow_q;
  assign tick_o       = tick;
  assign led_o        = led_q;

endmodule

// File: tb/tb_bcd_lap_stopwatch.sv
// tb/tb_bcd_lap_stopwatch.sv - directed bench for bcd_lap_stopwatch (wrapping and saturating instances)
module tb_bcd_lap_stopwatch;

  logic        clk;
  logic        rst;
  logic        start_stop;
  logic        lap;
  logic        clear;

  logic [7:0]  digits_w, digits_s;
  logic        running_w, running_s;
  logic        lap_active_w, lap_active_s;
  logic        overflow_w, overflow_s;
  logic        tick_w, tick_s;
  logic [14:0] led_w, led_s;

  int errors = 0;
  int checks = 0;

  bcd_lap_stopwatch #(.DIGITS(2), .TICK_DIV(4), .WRAP(1'b1), .LED_WIDTH(15)) dut_wrap (
    .clk_i(clk), .rst_i(rst), .start_stop_i(start_stop), .lap_i(lap), .clear_i(clear),
    .digits_o(digits_w), .running_o(running_w), .lap_active_o(lap_active_w),
    .overflow_o(overflow_w), .tick_o(tick_w), .led_o(led_w)
  );

  bcd_lap_stopwatch #(.DIGITS(2), .TICK_DIV(4), .WRAP(1'b0), .LED_WIDTH(15)) dut_sat (
    .clk_i(clk), .rst_i(rst), .start_stop_i(start_stop), .lap_i(lap), .clear_i(clear),
    .digits_o(digits_s), .running_o(running_s), .lap_active_o(lap_active_s),
    .overflow_o(overflow_s), .tick_o(tick_s), .led_o(led_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    cyc(1);
    start_stop = 1'b0;
  endtask

  task automatic pulse_lap();
    lap = 1'b1;
    cyc(1);
    lap = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    cyc(3);
    check("rst_digits", digits_w, 8'h00);
    check("rst_running", running_w, 1'b0);
    check("rst_lap_active", lap_active_w, 1'b0);
    check("rst_overflow", overflow_w, 1'b0);
    check("rst_tick", tick_w, 1'b0);
    check("rst_led", led_w, 15'h0001);
    rst = 1'b0;
    cyc(1);

    // First increment lands at E0+4, then every 4 cycles.
    pulse_ss();
    check("t1_running", running_w, 1'b1);
    cyc(2);
    check("t1_tick_early", tick_w, 1'b0);
    cyc(1);
    check("t1_tick_first", tick_w, 1'b1);
    check("t1_digits_pre", digits_w, 8'h00);
    cyc(1);
    check("t1_digits_01", digits_w, 8'h01);
    check("t1_tick_low", tick_w, 1'b0);
    cyc(36);
    check("t1_digits_10", digits_w, 8'h10);
    check("t1_led", led_w, 15'h0400);

    // Full scale: wrap instance rolls to 00, saturating instance pauses at 99.
    cyc(356);
    check("t2_digits_99", digits_w, 8'h99);
    check("t2_ovf_before", overflow_w, 1'b0);
    cyc(3);
    check("t2_tick_fs", tick_w, 1'b1);
    check("t2_sat_tick_fs", tick_s, 1'b1);
    cyc(1);
    check("t2_wrap_digits", digits_w, 8'h00);
    check("t2_wrap_ovf", overflow_w, 1'b1);
    check("t2_wrap_running", running_w, 1'b1);
    check("t2_sat_digits", digits_s, 8'h99);
    check("t2_sat_ovf", overflow_s, 1'b1);
    check("t2_sat_running", running_s, 1'b0);
    check("t2_sat_led", led_s, 15'h0200);

    // clear beats start_stop on the same edge.
    clear = 1'b1; start_stop = 1'b1;
    cyc(1);
    clear = 1'b0; start_stop = 1'b0;
    check("t5_running", running_w, 1'b0);
    check("t5_digits", digits_w, 8'h00);
    check("t5_overflow", overflow_w, 1'b0);
    check("t5_led", led_w, 15'h0001);
    check("t5_sat_overflow", overflow_s, 1'b0);

    // Lap freeze at 23 while counting continues underneath.
    pulse_ss();
    cyc(92);
    check("t3_digits_23", digits_w, 8'h23);
    pulse_lap();
    check("t3_lap_active", lap_active_w, 1'b1);
    cyc(20);
    check("t3_frozen", digits_w, 8'h23);
    check("t3_lap_running", running_w, 1'b1);
    pulse_lap();
    check("t3_live_28", digits_w, 8'h28);
    check("t3_lap_release", lap_active_w, 1'b0);

    // Pause with presc=2 and resume seamlessly.
    pulse_clear();
    pulse_ss();
    cyc(21);
    pulse_ss();
    check("t4_paused_digits", digits_w, 8'h05);
    check("t4_paused_running", running_w, 1'b0);
    cyc(50);
    check("t4_hold_digits", digits_w, 8'h05);
    check("t4_hold_tick", tick_w, 1'b0);
    pulse_ss();
    check("t4_resume_digits", digits_w, 8'h05);
    cyc(1);
    check("t4_resume_tick", tick_w, 1'b1);
    cyc(1);
    check("t4_resume_06", digits_w, 8'h06);

    // rst in LAP with pulses present behaves as power-on reset.
    pulse_lap();
    check("t6_in_lap", lap_active_w, 1'b1);
    cyc(5);
    rst = 1'b1; start_stop = 1'b1; lap = 1'b1;
    cyc(1);
    rst = 1'b0; start_stop = 1'b0; lap = 1'b0;
    check("t6_digits", digits_w, 8'h00);
    check("t6_running", running_w, 1'b0);
    check("t6_lap_active", lap_active_w, 1'b0);
    check("t6_overflow", overflow_w, 1'b0);
    check("t6_led", led_w, 15'h0001);
    check("t6_tick", tick_w, 1'b0);

    // lap is ignored in IDLE.
    pulse_lap();
    check("idle_lap_ignored", lap_active_w, 1'b0);
    cyc(6);
    check("idle_still", digits_w, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
